// File: rtl/wb_arbiter_pkg.sv
// Shared widths for the writeback arbiter slice: datapath defaults and entry layout.
package wb_arbiter_pkg;

    localparam int ZCRV_XLEN     = 32;
    localparam int ZCRV_REG_SIZE = 5;

    // Queued entry layout, MSB first: {wen, rd, data}.
    function automatic int wb_entry_w(input int reg_w, input int xlen);
        return 1 + reg_w + xlen;
    endfunction

endpackage

// File: rtl/wb_src_fifo.sv
// Per-source synchronous FIFO; pointers carry one extra wrap bit to tell full from empty.
module wb_src_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int W     = wb_entry_w(ZCRV_REG_SIZE, ZCRV_XLEN),
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [W-1:0] mem_q [DEPTH];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push_i) wptr_d = wptr_q + (AW+1)'(1);
            if (pop_i)  rptr_d = rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_i && !clr_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q[AW-1:0]];
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: per-source FIFOs merged onto one registered register-file write port.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int                 NUM_SRC    = 3,
    parameter int                 XLEN       = ZCRV_XLEN,
    parameter int                 REG_W      = ZCRV_REG_SIZE,
    parameter int                 BUF_DEPTH  = 2,
    parameter logic [NUM_SRC-1:0] FLUSH_MASK = 3'b011
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     kill_i,
    input  logic [NUM_SRC-1:0]       src_valid_i,
    output logic [NUM_SRC-1:0]       src_ready_o,
    input  logic [NUM_SRC-1:0]       src_wen_i,
    input  logic [NUM_SRC*REG_W-1:0] src_rd_i,
    input  logic [NUM_SRC*XLEN-1:0]  src_data_i,
    output logic                     rd_en_o,
    output logic [REG_W-1:0]         rd_index_o,
    output logic [XLEN-1:0]          rd_data_o,
    output logic                     retire_o,
    output logic                     busy_o
);
    localparam int EW  = wb_entry_w(REG_W, XLEN);
    localparam int RRW = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0]         full, empty, push, pop, clr, elig;
    logic [NUM_SRC-1:0][EW-1:0] head;
    logic [RRW-1:0]             rr_q, rr_d, gnt_idx;
    logic                       gnt_vld;
    logic [EW-1:0]              gnt_ent;

    logic                       rd_en_q, rd_en_d, retire_q, retire_d;
    logic [REG_W-1:0]           rd_idx_q, rd_idx_d;
    logic [XLEN-1:0]            rd_data_q, rd_data_d;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        // A flushed source neither accepts nor is granted in the flush cycle.
        assign clr[i]  = flush_i & FLUSH_MASK[i];
        assign push[i] = src_valid_i[i] & ~full[i] & ~clr[i];
        assign elig[i] = ~empty[i] & ~clr[i];
        assign pop[i]  = gnt_vld & (gnt_idx == RRW'(i));

        wb_src_fifo #(.W(EW), .DEPTH(BUF_DEPTH)) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr_i   (clr[i]),
            .push_i  (push[i]),
            .pop_i   (pop[i]),
            .wdata_i ({src_wen_i[i], src_rd_i[i*REG_W +: REG_W], src_data_i[i*XLEN +: XLEN]}),
            .rdata_o (head[i]),
            .full_o  (full[i]),
            .empty_o (empty[i])
        );
    end

    // Search starts one past the last winner, wrapping modulo NUM_SRC.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            int j;
            j = (int'(rr_q) + k) % NUM_SRC;
            if (!gnt_vld && elig[j]) begin
                gnt_vld = 1'b1;
                gnt_idx = RRW'(j);
            end
        end
    end

    assign gnt_ent = head[gnt_idx];
    assign rr_d    = gnt_vld ? gnt_idx : rr_q;

    always_comb begin
        rd_en_d   = gnt_vld & gnt_ent[EW-1] & (gnt_ent[EW-2 -: REG_W] != '0) & ~kill_i;
        retire_d  = gnt_vld & ~kill_i;
        rd_idx_d  = rd_en_d ? gnt_ent[EW-2 -: REG_W] : '0;
        rd_data_d = rd_en_d ? gnt_ent[XLEN-1:0] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q      <= RRW'(NUM_SRC-1);
            rd_en_q   <= 1'b0;
            retire_q  <= 1'b0;
            rd_idx_q  <= '0;
            rd_data_q <= '0;
        end else begin
            rr_q      <= rr_d;
            rd_en_q   <= rd_en_d;
            retire_q  <= retire_d;
            rd_idx_q  <= rd_idx_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign src_ready_o = ~full;
    assign rd_en_o     = rd_en_q;
    assign retire_o    = retire_q;
    assign rd_index_o  = rd_idx_q;
    assign rd_data_o   = rd_data_q;
    assign busy_o      = ~(&empty) | retire_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed plus random stimulus for wb_arbiter, checked against a queue-based reference model.
module tb_wb_arbiter;
    localparam int         N    = 3;
    localparam int         XL   = 32;
    localparam int         RW   = 5;
    localparam int         D    = 2;
    localparam logic [2:0] MASK = 3'b011;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush_i = 1'b0, kill_i = 1'b0;
    logic [N-1:0]    src_valid_i = '0, src_wen_i = '0, src_ready_o;
    logic [N*RW-1:0] src_rd_i = '0;
    logic [N*XL-1:0] src_data_i = '0;
    logic            rd_en_o, retire_o, busy_o;
    logic [RW-1:0]   rd_index_o;
    logic [XL-1:0]   rd_data_o;

    wb_arbiter #(.NUM_SRC(N), .XLEN(XL), .REG_W(RW), .BUF_DEPTH(D), .FLUSH_MASK(MASK)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .kill_i(kill_i),
        .src_valid_i(src_valid_i), .src_ready_o(src_ready_o), .src_wen_i(src_wen_i),
        .src_rd_i(src_rd_i), .src_data_i(src_data_i), .rd_en_o(rd_en_o),
        .rd_index_o(rd_index_o), .rd_data_o(rd_data_o), .retire_o(retire_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int ret_cnt  = 0;
    int rr_m;
    logic [1+RW+XL-1:0] q [N][$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) q[i].delete();
        rr_m = N - 1;
    endtask

    // One clock: drive at negedge, predict, check registered outputs just after posedge.
    task automatic cyc(input logic [2:0] v, input logic [2:0] w, input logic [14:0] rd,
                       input logic [95:0] dat, input logic fl, input logic kl);
        logic [2:0]  rdy;
        logic [37:0] e;
        int          win;
        logic        x_en, x_ret, x_busy;
        logic [4:0]  x_idx;
        logic [31:0] x_dat;
        src_valid_i = v; src_wen_i = w; src_rd_i = rd; src_data_i = dat;
        flush_i = fl; kill_i = kl;
        for (int i = 0; i < N; i++) rdy[i] = (q[i].size() < D);
        chk("ready", 64'(src_ready_o), 64'(rdy));
        win = -1;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (rr_m + k) % N;
            if (win < 0 && q[j].size() > 0 && !(fl && MASK[j])) win = j;
        end
        x_en = 1'b0; x_ret = 1'b0; x_idx = '0; x_dat = '0;
        if (win >= 0) begin
            e     = q[win].pop_front();
            rr_m  = win;
            x_ret = !kl;
            x_en  = e[37] && (e[36:32] != 0) && !kl;
            if (x_en) begin x_idx = e[36:32]; x_dat = e[31:0]; end
        end
        for (int i = 0; i < N; i++) if (fl && MASK[i]) q[i].delete();
        for (int i = 0; i < N; i++)
            if (v[i] && rdy[i] && !(fl && MASK[i])) q[i].push_back({w[i], rd[i*RW +: RW], dat[i*XL +: XL]});
        x_busy = x_ret;
        for (int i = 0; i < N; i++) if (q[i].size() > 0) x_busy = 1'b1;
        @(posedge clk); #1;
        chk("rd_en", 64'(rd_en_o), 64'(x_en));
        chk("rd_index", 64'(rd_index_o), 64'(x_idx));
        chk("rd_data", 64'(rd_data_o), 64'(x_dat));
        chk("retire", 64'(retire_o), 64'(x_ret));
        chk("busy", 64'(busy_o), 64'(x_busy));
        if (retire_o) ret_cnt++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(3'b000, 3'b000, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        src_valid_i = '0; flush_i = 1'b0; kill_i = 1'b0;
        model_reset();
        #1;
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_rd_en", 64'(rd_en_o), 64'd0);
        chk("rst_retire", 64'(retire_o), 64'd0);
        chk("rst_index", 64'(rd_index_o), 64'd0);
        chk("rst_data", 64'(rd_data_o), 64'd0);
        chk("rst_ready", 64'(src_ready_o), 64'h7);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int r0;
        @(negedge clk);
        do_reset();

        // Single write, two-cycle latency.
        cyc(3'b001, 3'b001, 15'd5, {64'd0, 32'hDEADBEEF}, 1'b0, 1'b0);
        cyc(3'b000, 3'b000, '0, '0, 1'b0, 1'b0);
        chk("t1_index", 64'(rd_index_o), 64'd5);
        chk("t1_data", 64'(rd_data_o), 64'hDEADBEEF);
        idle(1);
        chk("t1_busy_done", 64'(busy_o), 64'd0);

        // Simultaneous bursts drain round-robin.
        cyc(3'b111, 3'b111, {5'd3, 5'd2, 5'd1}, {32'hC3, 32'hB2, 32'hA1}, 1'b0, 1'b0);
        idle(3);
        cyc(3'b111, 3'b111, {5'd6, 5'd5, 5'd4}, {32'hC6, 32'hB5, 32'hA4}, 1'b0, 1'b0);
        cyc(3'b011, 3'b011, {5'd0, 5'd8, 5'd7}, {32'h0, 32'hB8, 32'hA7}, 1'b0, 1'b0);
        idle(5);

        // Back-pressure on src1 while all sources stream.
        do_reset();
        cyc(3'b111, 3'b111, {5'd11, 5'd12, 5'd13}, {32'h11, 32'h12, 32'h13}, 1'b0, 1'b0);
        cyc(3'b111, 3'b111, {5'd14, 5'd15, 5'd16}, {32'h14, 32'h15, 32'h16}, 1'b0, 1'b0);
        chk("t3_src1_full", 64'(src_ready_o[1]), 64'd0);
        cyc(3'b111, 3'b111, {5'd17, 5'd18, 5'd19}, {32'h17, 32'h18, 32'h19}, 1'b0, 1'b0);
        cyc(3'b111, 3'b111, {5'd20, 5'd21, 5'd22}, {32'h20, 32'h21, 32'h22}, 1'b0, 1'b0);
        idle(8);

        // Flush drops masked src0 entry, keeps src2.
        do_reset();
        r0 = ret_cnt;
        cyc(3'b101, 3'b101, {5'd10, 5'd0, 5'd9}, {32'hA10, 32'h0, 32'hA9}, 1'b0, 1'b0);
        cyc(3'b000, 3'b000, '0, '0, 1'b1, 1'b0);
        idle(4);
        chk("t4_retires", 64'(ret_cnt - r0), 64'd1);

        // Kill squashes only the current grant.
        cyc(3'b011, 3'b011, {5'd0, 5'd8, 5'd7}, {32'h0, 32'h88, 32'h77}, 1'b0, 1'b0);
        cyc(3'b000, 3'b000, '0, '0, 1'b0, 1'b1);
        idle(3);

        // Retire-only entries, then async reset with entries queued.
        cyc(3'b011, 3'b010, {5'd0, 5'd0, 5'd4}, {32'h0, 32'h55, 32'h44}, 1'b0, 1'b0);
        idle(3);
        cyc(3'b111, 3'b111, {5'd1, 5'd2, 5'd3}, {32'h1, 32'h2, 32'h3}, 1'b0, 1'b0);
        #2;
        do_reset();
        r0 = ret_cnt;
        idle(4);
        chk("t6_no_writes", 64'(ret_cnt - r0), 64'd0);

        // Random traffic with occasional flush/kill.
        for (int c = 0; c < 400; c++) begin
            cyc(3'($urandom), 3'($urandom), 15'($urandom), {$urandom, $urandom, $urandom},
                ($urandom % 16) == 0, ($urandom % 8) == 0);
        end
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
